// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings, widths and default latencies for the pipeline hazard controller.
// Also holds the single-source hazard rule so the top stays a thin wiring layer.
package pipe_ctrl_pkg;

    // Tuse: stage in which an ID-stage source register is first consumed.
    localparam logic [1:0] TUSE_ID   = 2'd0;
    localparam logic [1:0] TUSE_EX   = 2'd1;
    localparam logic [1:0] TUSE_NONE = 2'd3;

    // Tnew: cycles until a producer's result can be forwarded.
    localparam logic [1:0] TNEW_NOW  = 2'd0;
    localparam logic [1:0] TNEW_ONE  = 2'd1;
    localparam logic [1:0] TNEW_TWO  = 2'd2;

    localparam int MD_CNT_W         = 4;
    localparam int DEF_MULT_CYCLES  = 5;
    localparam int DEF_DIV_CYCLES   = 10;

    typedef logic [4:0] reg_idx_t;

    // A source stalls when a producer writing the same non-zero register
    // cannot deliver its value by the time the consumer needs it.
    function automatic logic src_hazard(
        input reg_idx_t   src,
        input logic [1:0] tuse,
        input reg_idx_t   ex_dst,
        input logic [1:0] ex_tnew,
        input reg_idx_t   mem_dst,
        input logic [1:0] mem_tnew
    );
        logic ex_hit;
        logic mem_hit;
        ex_hit  = (src == ex_dst)  && (ex_tnew  > tuse);
        mem_hit = (src == mem_dst) && (mem_tnew > tuse);
        src_hazard = (src != '0) && (tuse != TUSE_NONE) && (ex_hit || mem_hit);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of ID/EX/MEM hazard inputs and pipeline-register control outputs.
// slave is the controller's view; master is the pipeline (or bench) side.
interface pipe_hazard_ctrl_if;
   import pipe_ctrl_pkg::*;

   logic        freeze;
   reg_idx_t    id_rs;
   reg_idx_t    id_rt;
   logic [1:0]  id_tuse_rs;
   logic [1:0]  id_tuse_rt;
   logic        id_is_md;
   reg_idx_t    ex_dst;
   logic [1:0]  ex_tnew;
   reg_idx_t    mem_dst;
   logic [1:0]  mem_tnew;
   logic        ex_md_start;
   logic        ex_md_is_div;

   logic        en_pc;
   logic        en_if_id;
   logic        clr_id_ex;
   logic        en_ex_mem;
   logic        en_mem_wb;
   logic        stall;
   logic        md_busy;
   logic        md_err;
   logic [31:0] stall_cnt;

   modport slave (
      input  freeze, id_rs, id_rt, id_tuse_rs, id_tuse_rt, id_is_md,
             ex_dst, ex_tnew, mem_dst, mem_tnew, ex_md_start, ex_md_is_div,
      output en_pc, en_if_id, clr_id_ex, en_ex_mem, en_mem_wb,
             stall, md_busy, md_err, stall_cnt
   );

   modport master (
      output freeze, id_rs, id_rt, id_tuse_rs, id_tuse_rt, id_is_md,
             ex_dst, ex_tnew, mem_dst, mem_tnew, ex_md_start, ex_md_is_div,
      input  en_pc, en_if_id, clr_id_ex, en_ex_mem, en_mem_wb,
             stall, md_busy, md_err, stall_cnt
   );

endinterface

// File: rtl/md_busy_timer.sv
// Multiply/divide unit occupancy countdown with sticky overlap-error flag.
// Busy is decoded straight from the counter so an async reset drops it at once.
module md_busy_timer
   import pipe_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = DEF_MULT_CYCLES,
   parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic i_start,
   input  logic i_is_div,
   input  logic i_freeze,
   output logic o_busy,
   output logic o_err
);

   localparam logic [MD_CNT_W-1:0] MULT_LOAD = MD_CNT_W'(MULT_CYCLES);
   localparam logic [MD_CNT_W-1:0] DIV_LOAD  = MD_CNT_W'(DIV_CYCLES);

   logic [MD_CNT_W-1:0] r_cnt;
   logic                r_err;
   logic                w_busy;
   logic                w_load;

   assign w_busy = (r_cnt != '0);
   // A start that lands on a busy unit or a frozen cycle never reloads.
   assign w_load = i_start && !w_busy && !i_freeze;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
         r_err <= 1'b0;
      end else begin
         if (w_load) begin
            r_cnt <= i_is_div ? DIV_LOAD : MULT_LOAD;
         end else if (w_busy) begin
            r_cnt <= r_cnt - 1'b1;
         end
         if (i_start && w_busy) begin
            r_err <= 1'b1;
         end
      end
   end

   assign o_busy = w_busy;
   assign o_err  = r_err;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/bubble scheduler for the 5-stage pipeline: hazard detection, stage
// enable generation, MD-unit occupancy and a saturating stall counter.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = DEF_MULT_CYCLES,
   parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
   input  logic               clk,
   input  logic               reset,
   pipe_hazard_ctrl_if.slave  bus
);

   logic        w_haz_rs;
   logic        w_haz_rt;
   logic        w_md_haz;
   logic        w_md_busy;
   logic        w_md_err;
   logic        w_stall;
   logic        w_en_pc;
   logic        w_en_if_id;
   logic        w_clr_id_ex;
   logic        w_en_ex_mem;
   logic        w_en_mem_wb;
   logic [31:0] r_stall_cnt;

   md_busy_timer #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES)
   ) u_md_timer (
      .clk      (clk),
      .reset    (reset),
      .i_start  (bus.ex_md_start),
      .i_is_div (bus.ex_md_is_div),
      .i_freeze (bus.freeze),
      .o_busy   (w_md_busy),
      .o_err    (w_md_err)
   );

   assign w_haz_rs = src_hazard(bus.id_rs, bus.id_tuse_rs, bus.ex_dst, bus.ex_tnew,
                                bus.mem_dst, bus.mem_tnew);
   assign w_haz_rt = src_hazard(bus.id_rt, bus.id_tuse_rt, bus.ex_dst, bus.ex_tnew,
                                bus.mem_dst, bus.mem_tnew);

   // An MD op starting in EX this cycle occupies the unit just like a running one.
   assign w_md_haz = bus.id_is_md && (w_md_busy || bus.ex_md_start);
   assign w_stall  = !bus.freeze && (w_haz_rs || w_haz_rt || w_md_haz);

   always_comb begin
      w_en_pc     = 1'b1;
      w_en_if_id  = 1'b1;
      w_clr_id_ex = 1'b0;
      w_en_ex_mem = 1'b1;
      w_en_mem_wb = 1'b1;
      if (bus.freeze) begin
         w_en_pc     = 1'b0;
         w_en_if_id  = 1'b0;
         w_en_ex_mem = 1'b0;
         w_en_mem_wb = 1'b0;
      end else if (w_stall) begin
         // Hold PC and IF/ID, inject a bubble into EX, let older instrs drain.
         w_en_pc     = 1'b0;
         w_en_if_id  = 1'b0;
         w_clr_id_ex = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stall_cnt <= '0;
      end else if (w_stall && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign bus.en_pc     = w_en_pc;
   assign bus.en_if_id  = w_en_if_id;
   assign bus.clr_id_ex = w_clr_id_ex;
   assign bus.en_ex_mem = w_en_ex_mem;
   assign bus.en_mem_wb = w_en_mem_wb;
   assign bus.stall     = w_stall;
   assign bus.md_busy   = w_md_busy;
   assign bus.md_err    = w_md_err;
   assign bus.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a behavioural reference model is compared
// against the DUT every cycle, plus hand-computed literal checks per scenario.
module tb_pipe_hazard_ctrl;

   localparam int MULT_C = 5;
   localparam int DIV_C  = 10;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   bit   run_cmp = 1'b0;
   int   errors = 0;
   int   checks = 0;

   pipe_hazard_ctrl_if bus ();

   pipe_hazard_ctrl #(
      .MULT_CYCLES (MULT_C),
      .DIV_CYCLES  (DIV_C)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish, got running required done");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int     m_md_rem = 0;
   bit     m_err    = 1'b0;
   longint m_scnt   = 0;

   function automatic bit model_data_hazard();
      int src [2];
      int tuse[2];
      int dst [2];
      int tnew[2];
      bit h;
      src[0] = int'(bus.id_rs);   tuse[0] = int'(bus.id_tuse_rs);
      src[1] = int'(bus.id_rt);   tuse[1] = int'(bus.id_tuse_rt);
      dst[0] = int'(bus.ex_dst);  tnew[0] = int'(bus.ex_tnew);
      dst[1] = int'(bus.mem_dst); tnew[1] = int'(bus.mem_tnew);
      h = 1'b0;
      for (int s = 0; s < 2; s++)
         for (int p = 0; p < 2; p++)
            if (src[s] != 0 && tuse[s] != 3 && src[s] == dst[p] && tnew[p] > tuse[s])
               h = 1'b1;
      return h;
   endfunction

   function automatic bit model_stall();
      bit md_h;
      md_h = bus.id_is_md && (m_md_rem > 0 || bus.ex_md_start);
      return !bus.freeze && (model_data_hazard() || md_h);
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_md_rem = 0;
         m_err    = 1'b0;
         m_scnt   = 0;
      end else begin
         bit st;
         bit busy;
         st   = model_stall();
         busy = (m_md_rem > 0);
         if (bus.ex_md_start && busy) m_err = 1'b1;
         if (bus.ex_md_start && !busy && !bus.freeze)
            m_md_rem = bus.ex_md_is_div ? DIV_C : MULT_C;
         else if (busy)
            m_md_rem = m_md_rem - 1;
         if (st && m_scnt < 64'hFFFF_FFFF) m_scnt = m_scnt + 1;
      end
   end

   always @(negedge clk) begin
      if (run_cmp) begin
         bit st;
         bit fz;
         st = model_stall();
         fz = bus.freeze;
         chk("cmp_stall",     32'(bus.stall),     32'(st));
         chk("cmp_en_pc",     32'(bus.en_pc),     32'(!fz && !st));
         chk("cmp_en_if_id",  32'(bus.en_if_id),  32'(!fz && !st));
         chk("cmp_clr_id_ex", 32'(bus.clr_id_ex), 32'(st));
         chk("cmp_en_ex_mem", 32'(bus.en_ex_mem), 32'(!fz));
         chk("cmp_en_mem_wb", 32'(bus.en_mem_wb), 32'(!fz));
         chk("cmp_md_busy",   32'(bus.md_busy),   32'(m_md_rem > 0));
         chk("cmp_md_err",    32'(bus.md_err),    32'(m_err));
         chk("cmp_stall_cnt", bus.stall_cnt,      32'(m_scnt));
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.freeze       = 1'b0;
      bus.id_rs        = 5'd0;
      bus.id_rt        = 5'd0;
      bus.id_tuse_rs   = 2'd3;
      bus.id_tuse_rt   = 2'd3;
      bus.id_is_md     = 1'b0;
      bus.ex_dst       = 5'd0;
      bus.ex_tnew      = 2'd0;
      bus.mem_dst      = 5'd0;
      bus.mem_tnew     = 2'd0;
      bus.ex_md_start  = 1'b0;
      bus.ex_md_is_div = 1'b0;
   endtask

   task automatic load_use();
      bus.id_rs      = 5'd5;
      bus.id_tuse_rs = 2'd0;
      bus.ex_dst     = 5'd5;
      bus.ex_tnew    = 2'd2;
   endtask

   initial begin
      int nbusy;
      idle();
      run_cmp = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      step();
      $display("tb: reset state");
      chk("rst_en_pc", 32'(bus.en_pc), 32'd1);
      chk("rst_stall", 32'(bus.stall), 32'd0);
      chk("rst_md_busy", 32'(bus.md_busy), 32'd0);
      chk("rst_md_err", 32'(bus.md_err), 32'd0);
      chk("rst_stall_cnt", bus.stall_cnt, 32'd0);

      $display("tb: load-use hazard rs=5 ex_tnew=2");
      load_use();
      #2;
      chk("lu_stall", 32'(bus.stall), 32'd1);
      chk("lu_en_pc", 32'(bus.en_pc), 32'd0);
      chk("lu_en_if_id", 32'(bus.en_if_id), 32'd0);
      chk("lu_clr_id_ex", 32'(bus.clr_id_ex), 32'd1);
      chk("lu_en_mem_wb", 32'(bus.en_mem_wb), 32'd1);
      chk("lu_en_ex_mem", 32'(bus.en_ex_mem), 32'd1);
      step();
      idle();

      $display("tb: mem forwarding rt=7 tuse 1 then 0");
      bus.id_rt = 5'd7; bus.id_tuse_rt = 2'd1; bus.mem_dst = 5'd7; bus.mem_tnew = 2'd1;
      #2 chk("fwd_tuse1_stall", 32'(bus.stall), 32'd0);
      bus.id_tuse_rt = 2'd0;
      #2 chk("fwd_tuse0_stall", 32'(bus.stall), 32'd1);
      step();
      chk("fwd_stall_cnt", bus.stall_cnt, 32'd2);
      idle();

      $display("tb: zero register and unused source");
      bus.id_rs = 5'd0; bus.id_tuse_rs = 2'd0; bus.ex_dst = 5'd0; bus.ex_tnew = 2'd2;
      #2 chk("zero_stall", 32'(bus.stall), 32'd0);
      bus.id_rs = 5'd9; bus.id_tuse_rs = 2'd3; bus.ex_dst = 5'd9; bus.mem_dst = 5'd9;
      bus.mem_tnew = 2'd1;
      #2 chk("unused_stall", 32'(bus.stall), 32'd0);
      step();
      idle();

      $display("tb: divide occupancy");
      bus.ex_md_start = 1'b1; bus.ex_md_is_div = 1'b1;
      step();
      idle();
      bus.id_is_md = 1'b1;
      nbusy = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus.md_busy) nbusy++;
      end
      chk("div_busy_cycles", 32'(nbusy), 32'd10);
      chk("div_stall_cnt", bus.stall_cnt, 32'd12);
      step();
      idle();

      $display("tb: mult start with overlapping second start");
      bus.ex_md_start = 1'b1;
      step();
      bus.ex_md_start = 1'b0;
      step();
      bus.ex_md_start = 1'b1;
      step();
      bus.ex_md_start = 1'b0;
      chk("ovl_md_err", 32'(bus.md_err), 32'd1);
      chk("ovl_busy_c", 32'(bus.md_busy), 32'd1);
      step();
      step();
      chk("ovl_busy_e", 32'(bus.md_busy), 32'd1);
      step();
      chk("ovl_busy_f", 32'(bus.md_busy), 32'd0);
      idle();

      $display("tb: async reset mid-divide");
      bus.ex_md_start = 1'b1; bus.ex_md_is_div = 1'b1;
      step();
      bus.ex_md_start = 1'b0; bus.id_is_md = 1'b1;
      step();
      #2 reset = 1'b0;
      #1;
      chk("arst_md_busy", 32'(bus.md_busy), 32'd0);
      chk("arst_stall_cnt", bus.stall_cnt, 32'd0);
      chk("arst_md_err", 32'(bus.md_err), 32'd0);
      step();
      reset = 1'b1;
      idle();

      $display("tb: freeze over a hazard");
      load_use();
      bus.freeze = 1'b1;
      #2;
      chk("frz_en_pc", 32'(bus.en_pc), 32'd0);
      chk("frz_en_if_id", 32'(bus.en_if_id), 32'd0);
      chk("frz_en_ex_mem", 32'(bus.en_ex_mem), 32'd0);
      chk("frz_en_mem_wb", 32'(bus.en_mem_wb), 32'd0);
      chk("frz_clr_id_ex", 32'(bus.clr_id_ex), 32'd0);
      chk("frz_stall", 32'(bus.stall), 32'd0);
      step();
      chk("frz_stall_cnt", bus.stall_cnt, 32'd0);
      bus.ex_md_start = 1'b1; bus.id_is_md = 1'b1;
      step();
      chk("frz_start_busy", 32'(bus.md_busy), 32'd0);
      chk("frz_start_err", 32'(bus.md_err), 32'd0);

      $display("tb: countdown continues while frozen");
      bus.freeze = 1'b0; bus.ex_md_is_div = 1'b1;
      step();
      bus.ex_md_start = 1'b0;
      bus.freeze = 1'b1;
      repeat (4) step();
      bus.freeze = 1'b0;
      nbusy = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus.md_busy) nbusy++;
      end
      chk("frz_busy_left", 32'(nbusy), 32'd6);
      step();
      idle();
      repeat (2) step();

      run_cmp = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
